// File: rtl/apb_requester.sv
// ---------------------------------------------------------------------------
// apb_pkg / apb_requester
//
// APB requester (manager) sitting directly upstream of the APB completer.
// Accepts commands on a valid/ready port, runs them as APB SETUP/ACCESS
// transfers and reports each completion as a one-cycle pulse on the response
// port. Back-to-back commands are chained with psel held high.
//
// Optional feature (compile-time macro):
//   APB_REQ_TIMEOUT_EN - abort an ACCESS phase that sees no pready for
//                        TIMEOUT cycles and report it as an error response.
//
// Parameters:
//   ADDR_WIDTH  APB address width (default from apb_pkg)
//   DATA_WIDTH  APB data width, multiple of 8 (default from apb_pkg)
//   STRB_WIDTH  write strobe width, DATA_WIDTH/8
//   TIMEOUT     ACCESS cycles without pready before abort, 1..255
//               (only meaningful with APB_REQ_TIMEOUT_EN)
//
// Ports:
//   pclk, presetn          clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready    command handshake
//   cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot   command fields
//   rsp_valid, rsp_rdata, rsp_err                        completion pulse
//   psel, penable, pwrite, paddr, pwdata, pstrb, pprot   APB request
//   prdata, pready, pslverr                              APB completion
// ---------------------------------------------------------------------------

package apb_pkg;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
endpackage

module apb_requester #(
    parameter int ADDR_WIDTH = apb_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = apb_pkg::DATA_WIDTH,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  pclk,
    input  logic                  presetn,
    // command port
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_strb,
    input  logic [2:0]            cmd_prot,
    // response port
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    // APB bus
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic [STRB_WIDTH-1:0] pstrb,
    output logic [2:0]            pprot,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    // Elaboration-time parameter sanity checks.
    if (DATA_WIDTH % 8 != 0) begin : gBadDataWidth
        $error("apb_requester: DATA_WIDTH must be a multiple of 8");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : gBadTimeout
        $error("apb_requester: TIMEOUT must be in 1..255");
    end

    // Encoding chosen so psel and penable are plain flop bits (glitch-free):
    // bit 0 = psel, bit 1 = penable.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b11
    } stateT;

    stateT state;
    stateT stateNext;

    logic handshake;
    logic accessDone;
    logic timeoutAbort;

    assign psel    = state[0];
    assign penable = state[1];

    // A new command may be taken while idle, or in the last ACCESS cycle of
    // the current transfer so the next one chains without dropping psel.
    assign cmd_ready  = (state == IDLE) || ((state == ACCESS) && pready);
    assign handshake  = cmd_valid && cmd_ready;
    assign accessDone = (state == ACCESS) && pready;

`ifdef APB_REQ_TIMEOUT_EN
    // Counts ACCESS cycles without pready. Abort is decided in the cycle the
    // count would reach TIMEOUT; a pready in that same cycle completes
    // normally because the abort term requires !pready.
    localparam logic [7:0] LastWait = 8'(TIMEOUT - 1);

    logic [7:0] waitCount;

    assign timeoutAbort = (state == ACCESS) && !pready && (waitCount == LastWait);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            waitCount <= '0;
        end else if (state == SETUP) begin
            waitCount <= '0;
        end else if ((state == ACCESS) && !pready) begin
            waitCount <= waitCount + 8'd1;
        end
    end
`else
    assign timeoutAbort = 1'b0;
`endif

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        // NOTE: default assigned first so no path through the case leaves
        // stateNext unassigned, which would infer a latch.
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (handshake) begin
                    stateNext = SETUP;
                end
            end
            SETUP: begin
                stateNext = ACCESS;
            end
            ACCESS: begin
                if (accessDone) begin
                    stateNext = cmd_valid ? SETUP : IDLE;
                end else if (timeoutAbort) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // APB request fields and response registers.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            pstrb     <= '0;
            pprot     <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            if (handshake) begin
                pwrite <= cmd_write;
                paddr  <= cmd_addr;
                pprot  <= cmd_prot;
                pstrb  <= cmd_write ? cmd_strb : '0;
                // Reads leave pwdata at its last written value.
                if (cmd_write) begin
                    pwdata <= cmd_wdata;
                end
            end

            // pwrite here is still the completing transfer's value even when
            // a chained command is loaded on the same edge.
            rsp_valid <= accessDone || timeoutAbort;
            rsp_err   <= accessDone ? pslverr : timeoutAbort;
            rsp_rdata <= (accessDone && !pwrite && !pslverr) ? prdata : '0;
        end
    end

endmodule

// File: tb/tb_apb_requester.sv
// ---------------------------------------------------------------------------
// tb_apb_requester
//
// Bench for apb_requester. A completer model answers the bus with a
// per-transfer wait-state count and flags misaligned addresses with pslverr.
// A transfer-level reference model predicts every DUT output each cycle from
// the accepted commands; directed scenarios pin the model with literal
// latencies and data. Build with +define+APB_REQ_TIMEOUT_EN to cover the
// watchdog.
// ---------------------------------------------------------------------------

module tb_apb_requester;

    localparam int AW = apb_pkg::ADDR_WIDTH;
    localparam int DW = apb_pkg::DATA_WIDTH;
    localparam int SW = DW / 8;
    localparam int TO = 4;

`ifdef APB_REQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          pclk = 1'b0;
    logic          presetn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [SW-1:0] cmd_strb = '0;
    logic [2:0]    cmd_prot = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [SW-1:0] pstrb;
    logic [2:0]    pprot;
    logic [DW-1:0] prdata = '0;
    logic          pready = 1'b0;
    logic          pslverr = 1'b0;

    apb_requester #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .STRB_WIDTH (SW),
        .TIMEOUT    (TO)
    ) dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_strb  (cmd_strb),
        .cmd_prot  (cmd_prot),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pstrb     (pstrb),
        .pprot     (pprot),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    always #5 pclk = ~pclk;

    // ---------------- checking helpers ----------------
    int nTests = 0;
    int nFail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic boundFail(input string name);
        nTests++;
        nFail++;
        $display("FAIL %s: DUT event did not occur within its cycle budget (t=%0t)", name, $time);
    endtask

    // Completer policy: any address not word-aligned gets pslverr.
    function automatic logic misaligned(input logic [AW-1:0] a);
        return a[1:0] != 2'b00;
    endfunction

    // ---------------- completer model ----------------
    logic [DW-1:0] slaveMem [16];
    int            wsQ [$];
    int            curWs  = 0;
    int            accCnt = 0;

    always @(posedge pclk) begin
        #1;
        if (psel && !penable) begin
            curWs  = (wsQ.size() > 0) ? wsQ.pop_front() : 0;
            accCnt = 0;
        end
        if (psel && penable) begin
            pready  = (accCnt == curWs);
            pslverr = pready ? misaligned(paddr) : 1'($urandom);
            if (pready && !pwrite && !misaligned(paddr)) prdata = slaveMem[paddr[5:2]];
            else                                         prdata = $urandom;
            if (pready && pwrite && !misaligned(paddr)) begin
                for (int b = 0; b < SW; b++) begin
                    if (pstrb[b]) slaveMem[paddr[5:2]][8*b +: 8] = pwdata[8*b +: 8];
                end
            end
            accCnt++;
        end else begin
            // Noise outside ACCESS: the requester must ignore it.
            pready  = 1'($urandom);
            pslverr = 1'($urandom);
            prdata  = $urandom;
        end
    end

    // ---------------- transfer-level reference model ----------------
    typedef struct packed {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
        logic [2:0]    prot;
    } cmdT;

    logic [DW-1:0] refMem [16];
    int            cyc    = 0;
    bit            mBusy  = 1'b0;
    int            mSetup = 0;
    cmdT           mCur   = '0;
    logic          eWrite = 1'b0;
    logic [AW-1:0] eAddr  = '0;
    logic [DW-1:0] eWdata = '0;
    logic [SW-1:0] eStrb  = '0;
    logic [2:0]    eProt  = '0;
    logic          eRspValid = 1'b0;
    logic          eRspErr   = 1'b0;
    logic [DW-1:0] eRspRdata = '0;

    // A busy transfer has psel high from its setup cycle until completion and
    // penable high from the cycle after setup; completion is the first
    // penable cycle with pready, abort the TIMEOUT-th one without it.
    always @(negedge pclk) begin
        logic ePsel, ePen, eReady, done, abort;
        int   k;
        cyc++;
        if (!presetn) begin
            check("rst_psel", psel, 0);
            check("rst_penable", penable, 0);
            check("rst_pwrite", pwrite, 0);
            check("rst_paddr", paddr, 0);
            check("rst_pwdata", pwdata, 0);
            check("rst_pstrb", pstrb, 0);
            check("rst_pprot", pprot, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_rsp_err", rsp_err, 0);
            check("rst_rsp_rdata", rsp_rdata, 0);
            mBusy = 1'b0; eWrite = 1'b0; eAddr = '0; eWdata = '0; eStrb = '0; eProt = '0;
            eRspValid = 1'b0; eRspErr = 1'b0; eRspRdata = '0;
        end else begin
            ePsel  = mBusy;
            ePen   = mBusy && (cyc > mSetup);
            eReady = !mBusy || (ePen && pready);
            check("psel", psel, ePsel);
            check("penable", penable, ePen);
            check("cmd_ready", cmd_ready, eReady);
            check("pwrite", pwrite, eWrite);
            check("paddr", paddr, eAddr);
            check("pwdata", pwdata, eWdata);
            check("pstrb", pstrb, eStrb);
            check("pprot", pprot, eProt);
            check("rsp_valid", rsp_valid, eRspValid);
            check("rsp_err", rsp_err, eRspErr);
            check("rsp_rdata", rsp_rdata, eRspRdata);

            k     = cyc - mSetup;
            done  = ePen && pready;
            abort = TO_EN && ePen && !pready && (k == TO);
            eRspValid = done || abort;
            eRspErr   = done ? misaligned(mCur.addr) : abort;
            eRspRdata = (done && !mCur.write && !misaligned(mCur.addr)) ? refMem[mCur.addr[5:2]] : '0;
            if (done && mCur.write && !misaligned(mCur.addr)) begin
                for (int b = 0; b < SW; b++) begin
                    if (mCur.strb[b]) refMem[mCur.addr[5:2]][8*b +: 8] = mCur.wdata[8*b +: 8];
                end
            end
            if (cmd_valid && eReady) begin
                mBusy  = 1'b1;
                mSetup = cyc + 1;
                mCur   = '{cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot};
                eWrite = cmd_write;
                eAddr  = cmd_addr;
                eProt  = cmd_prot;
                eStrb  = cmd_write ? cmd_strb : '0;
                if (cmd_write) eWdata = cmd_wdata;
            end else if (done || abort) begin
                mBusy = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    // Call at posedge+1; returns at posedge+1 of the cycle after the handshake.
    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] s, input logic [2:0] p, input int ws);
        int n = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s; cmd_prot = p;
        forever begin
            @(negedge pclk);
            if (cmd_ready) break;
            n++;
            if (n > 400) begin
                boundFail("accept");
                break;
            end
            @(posedge pclk);
            #1;
        end
        @(posedge pclk);
        wsQ.push_back(ws);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Issue one command and measure it: lat = cycles from handshake edge to
    // the rsp_valid cycle, plus psel/penable cycle counts on the way.
    task automatic runCmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s, input logic [2:0] p, input int ws,
                          output int lat, output int nPsel, output int nPen,
                          output logic [DW-1:0] rd, output logic er);
        bit seen = 1'b0;
        issue(w, a, d, s, p, ws);
        lat = 0; nPsel = 0; nPen = 0; rd = '0; er = 1'b0;
        repeat (400) begin
            @(negedge pclk);
            lat++;
            if (psel) nPsel++;
            if (penable) nPen++;
            if (rsp_valid) begin
                rd = rsp_rdata;
                er = rsp_err;
                seen = 1'b1;
                break;
            end
        end
        if (!seen) boundFail("response");
        @(posedge pclk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", nTests, nFail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, np, ne;
        logic [DW-1:0] rd;
        logic er;
        int rspCyc [$];
        int drops, readyCnt, k, n;
        bit started, acc;
        cmdT b2b [3];

        for (int i = 0; i < 16; i++) begin
            slaveMem[i] = '0;
            refMem[i]   = '0;
        end

        // Reset state
        repeat (3) @(negedge pclk);
        check("reset_psel", psel, 1'b0);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_cmd_ready", cmd_ready, 1'b1);
        @(posedge pclk);
        #1;
        presetn = 1'b1;

        // Zero-wait write
        runCmd(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 3'd0, 0, lat, np, ne, rd, er);
        check("wr_latency", lat, 3);
        check("wr_psel_cycles", np, 2);
        check("wr_penable_cycles", ne, 1);
        check("wr_rsp_err", er, 1'b0);
        check("wr_rsp_rdata", rd, 32'h0);

        // Read back with two wait states
        runCmd(1'b0, 32'h0000_0004, 32'h0, 4'hF, 3'd2, 2, lat, np, ne, rd, er);
        check("rd_latency", lat, 5);
        check("rd_penable_cycles", ne, 3);
        check("rd_rsp_rdata", rd, 32'hDEAD_BEEF);
        check("rd_rsp_err", er, 1'b0);

        // Three chained commands with cmd_valid held high
        b2b[0] = '{1'b1, 32'h10, 32'h1111_1111, 4'hF, 3'd1};
        b2b[1] = '{1'b1, 32'h14, 32'h2222_2222, 4'h3, 3'd0};
        b2b[2] = '{1'b0, 32'h10, 32'h0, 4'h0, 3'd4};
        drops = 0; readyCnt = 0; k = 0; started = 1'b0;
        cmd_valid = 1'b1;
        {cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot} = b2b[0];
        for (int t = 0; t < 40 && rspCyc.size() < 3; t++) begin
            @(negedge pclk);
            if (rsp_valid) rspCyc.push_back(t);
            if (psel) started = 1'b1;
            if (started && !psel && rspCyc.size() < 3) drops++;
            if (psel && cmd_ready) readyCnt++;
            acc = cmd_valid && cmd_ready;
            @(posedge pclk);
            if (acc) wsQ.push_back(0);
            #1;
            if (acc) begin
                k++;
                if (k < 3) {cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot} = b2b[k];
                else cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        check("b2b_rsp_count", rspCyc.size(), 3);
        if (rspCyc.size() == 3) begin
            check("b2b_gap1", rspCyc[1] - rspCyc[0], 2);
            check("b2b_gap2", rspCyc[2] - rspCyc[1], 2);
        end
        check("b2b_psel_drops", drops, 0);
        check("b2b_ready_cycles", readyCnt, 3);

        // Misaligned read -> slave error
        runCmd(1'b0, 32'h0000_0002, 32'h0, 4'hF, 3'd0, 0, lat, np, ne, rd, er);
        check("mis_rsp_err", er, 1'b1);
        check("mis_rsp_rdata", rd, 32'h0);
        @(negedge pclk);
        check("mis_idle_psel", psel, 1'b0);
        check("mis_idle_ready", cmd_ready, 1'b1);
        @(posedge pclk);
        #1;

        // Reset while stalled in ACCESS
        issue(1'b0, 32'h0000_0008, 32'h0, 4'hF, 3'd0, 50);
        n = 0;
        forever begin
            @(negedge pclk);
            if (penable) break;
            n++;
            if (n > 10) begin
                boundFail("reach_access");
                break;
            end
        end
        #2;
        presetn = 1'b0;
        #1;
        check("rst_mid_psel", psel, 1'b0);
        check("rst_mid_penable", penable, 1'b0);
        repeat (2) begin
            @(negedge pclk);
            check("rst_mid_no_rsp", rsp_valid, 1'b0);
        end
        @(posedge pclk);
        #1;
        presetn = 1'b1;
        runCmd(1'b1, 32'h0000_0008, 32'h1234_5678, 4'b0011, 3'd0, 0, lat, np, ne, rd, er);
        check("post_rst_latency", lat, 3);
        check("post_rst_psel_cycles", np, 2);

        // pready on the 4th ACCESS cycle completes normally
        runCmd(1'b0, 32'h0000_0004, 32'h0, 4'hF, 3'd0, 3, lat, np, ne, rd, er);
        check("w3_latency", lat, 6);
        check("w3_penable_cycles", ne, 4);
        check("w3_rsp_err", er, 1'b0);
        check("w3_rsp_rdata", rd, 32'hDEAD_BEEF);

`ifdef APB_REQ_TIMEOUT_EN
        // pready never arrives -> abort after TIMEOUT ACCESS cycles
        runCmd(1'b0, 32'h0000_0004, 32'h0, 4'hF, 3'd0, 200, lat, np, ne, rd, er);
        check("to_latency", lat, 6);
        check("to_penable_cycles", ne, 4);
        check("to_rsp_err", er, 1'b1);
        check("to_rsp_rdata", rd, 32'h0);
`else
        // Without the watchdog a long stall simply waits
        runCmd(1'b0, 32'h0000_0004, 32'h0, 4'hF, 3'd0, 20, lat, np, ne, rd, er);
        check("long_latency", lat, 23);
        check("long_penable_cycles", ne, 21);
        check("long_rsp_rdata", rd, 32'hDEAD_BEEF);
`endif

        // Randomized traffic, checked cycle by cycle by the model
        for (int i = 0; i < 250; i++) begin
            logic [AW-1:0] a;
            int g, ws;
            g = $urandom_range(0, 2);
            repeat (g) begin
                @(posedge pclk);
                #1;
            end
            a  = AW'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            ws = TO_EN ? $urandom_range(0, 5) : $urandom_range(0, 3);
            issue(1'($urandom), a, $urandom, SW'($urandom), 3'($urandom), ws);
        end
        repeat (20) @(posedge pclk);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
